// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ producers,
// with a per-register busy scoreboard that raises RAW stalls and blocks WAW issues.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int REG_SIZE   = 16,
  parameter int REG_NUMBER = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    i_req_addr,
  input  logic [NUM_REQ*REG_SIZE-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_rf_we,
  output logic [ADDR_W-1:0]            o_rf_waddr,
  output logic [REG_SIZE-1:0]          o_rf_wdata,
  input  logic                         i_issue_valid,
  input  logic [ADDR_W-1:0]            i_issue_addr,
  output logic                         o_issue_ready,
  input  logic                         i_rd_en1,
  input  logic [ADDR_W-1:0]            i_rd_addr1,
  input  logic                         i_rd_en2,
  input  logic [ADDR_W-1:0]            i_rd_addr2,
  output logic                         o_stall,
  output logic [REG_NUMBER-1:0]        o_busy_mask
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_waddr;
  logic [REG_SIZE-1:0]   r_wdata;
  logic [REG_NUMBER-1:0] r_busy;

  logic [ADDR_W-1:0]     w_addr_arr [NUM_REQ];
  logic [REG_SIZE-1:0]   w_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [PTR_W-1:0]      w_ptr_next;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [REG_SIZE-1:0]   w_sel_data;
  logic                  w_issue_fire;
  logic [REG_NUMBER-1:0] w_set_mask;
  logic [REG_NUMBER-1:0] w_clr_mask;
  logic [REG_NUMBER-1:0] w_busy_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi] = i_req_data[gi*REG_SIZE +: REG_SIZE];
  end

  // Round-robin search from r_ptr, wrapping modulo NUM_REQ; first valid index wins
  always_comb begin : p_arbitrate
    int               v_sum;
    logic [PTR_W-1:0] v_idx;
    logic             v_hit;
    w_grant    = '0;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    v_sum      = 0;
    v_idx      = '0;
    v_hit      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum      = int'(r_ptr) + k;
      v_idx      = PTR_W'((v_sum >= NUM_REQ) ? (v_sum - NUM_REQ) : v_sum);
      v_hit      = i_req_valid[v_idx] & ~w_gnt_any;
      w_grant[v_idx] = w_grant[v_idx] | v_hit;
      w_gnt_idx  = v_hit ? v_idx : w_gnt_idx;
      w_sel_addr = v_hit ? w_addr_arr[v_idx] : w_sel_addr;
      w_sel_data = v_hit ? w_data_arr[v_idx] : w_sel_data;
      w_gnt_any  = w_gnt_any | v_hit;
    end
  end

  // Pointer moves to the slot after the winner
  always_comb begin : p_ptr_next
    w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + PTR_W'(1));
  end

  // Scoreboard next state: a set on the same register as a clear takes priority
  always_comb begin : p_busy_next
    w_issue_fire = i_issue_valid & ~r_busy[i_issue_addr] & ~rst;
    w_set_mask   = '0;
    w_clr_mask   = '0;
    for (int r = 0; r < REG_NUMBER; r++) begin
      w_set_mask[r] = w_issue_fire & (i_issue_addr == ADDR_W'(r));
      w_clr_mask[r] = r_we & (r_waddr == ADDR_W'(r));
    end
    w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  // Write port, arbitration pointer and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_we   <= w_gnt_any;
      r_busy <= w_busy_next;
      if (w_gnt_any) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_ptr   <= w_ptr_next;
      end
    end
  end

  assign o_req_ready   = w_grant & {NUM_REQ{~rst}};
  assign o_issue_ready = ~rst & ~r_busy[i_issue_addr];
  // No bypass: the register stays busy through the cycle its write is on the port
  assign o_stall       = (i_rd_en1 & r_busy[i_rd_addr1]) | (i_rd_en2 & r_busy[i_rd_addr2]);
  assign o_rf_we       = r_we;
  assign o_rf_waddr    = r_waddr;
  assign o_rf_wdata    = r_wdata;
  assign o_busy_mask   = r_busy;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus protocol-legal random
// traffic checked against a behavioural model of the arbitration and scoreboard rules.
module tb_rf_write_arbiter;
  localparam int NR = 3;
  localparam int RS = 16;
  localparam int RN = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*RS-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [RS-1:0]     rf_wdata;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_ready;
  logic              rd_en1, rd_en2;
  logic [AW-1:0]     rd_addr1, rd_addr2;
  logic              stall;
  logic [RN-1:0]     busy_mask;

  logic              q_valid [NR];
  logic [AW-1:0]     q_addr  [NR];
  logic [RS-1:0]     q_data  [NR];

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int                m_ptr = 0;
  logic              m_we = 1'b0;
  logic [AW-1:0]     m_waddr = '0;
  logic [RS-1:0]     m_wdata = '0;
  logic [RN-1:0]     m_busy = '0;

  rf_write_arbiter #(.NUM_REQ(NR), .REG_SIZE(RS), .REG_NUMBER(RN), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .i_issue_valid(issue_valid), .i_issue_addr(issue_addr), .o_issue_ready(issue_ready),
    .i_rd_en1(rd_en1), .i_rd_addr1(rd_addr1), .i_rd_en2(rd_en2), .i_rd_addr2(rd_addr2),
    .o_stall(stall), .o_busy_mask(busy_mask)
  );

  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = q_valid[i];
      req_addr[i*AW +: AW] = q_addr[i];
      req_data[i*RS +: RS] = q_data[i];
    end
  end

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      int g = (m_ptr + k) % NR;
      if (q_valid[g]) return g;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r = '0;
    int g = model_grant();
    if (!rst && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_issue_ready();
    return !rst && !m_busy[issue_addr];
  endfunction

  function automatic logic exp_stall();
    return (rd_en1 && m_busy[rd_addr1]) || (rd_en2 && m_busy[rd_addr2]);
  endfunction

  task automatic model_clock();
    logic [RN-1:0] nb;
    int g;
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_waddr] = 1'b0;
      if (issue_valid && !m_busy[issue_addr]) nb[issue_addr] = 1'b1;
      g = model_grant();
      if (g >= 0) begin
        m_we = 1'b1; m_waddr = q_addr[g]; m_wdata = q_data[g]; m_ptr = (g + 1) % NR;
      end else begin
        m_we = 1'b0;
      end
      m_busy = nb;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      q_valid[i] = 1'b0; q_addr[i] = '0; q_data[i] = '0;
    end
    issue_valid = 1'b0; issue_addr = '0;
    rd_en1 = 1'b0; rd_addr1 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      q_valid[i] = 1'b1; q_addr[i] = AW'(i + 1); q_data[i] = RS'($urandom);
    end
    issue_valid = 1'b1; issue_addr = 3'd2;
    @(negedge clk);
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got=%b exp=000", req_ready); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL reset_issue_ready got=%b exp=0", issue_ready); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (busy_mask !== 8'h00) begin failures++; $display("FAIL reset_busy got=%h exp=00", busy_mask); end
    checks++; if (rf_waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 16'h0000) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", rf_wdata); end
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    q_valid[0] = 1'b1; q_addr[0] = 3'd5; q_data[0] = 16'hBEEF;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_grant got=%b exp=001", req_ready); end
    tick();
    q_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 3'd5) begin failures++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 16'hBEEF) begin failures++; $display("FAIL single_wdata got=%h exp=beef", rf_wdata); end
    tick();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_we_drop got=%b exp=0", rf_we); end
    checks++; if (rf_wdata !== 16'hBEEF) begin failures++; $display("FAIL single_wdata_hold got=%h exp=beef", rf_wdata); end
    tick();
  endtask

  task automatic test_rotation();
    logic [NR-1:0] e;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      q_valid[i] = 1'b1; q_addr[i] = AW'(i); q_data[i] = RS'(16'hA000 + i);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = 3'b001 << (c % 3);
      checks++; if (req_ready !== e) begin failures++; $display("FAIL rotate_grant c=%0d got=%b exp=%b", c, req_ready, e); end
      if (c > 0) begin
        checks++;
        if (rf_waddr !== AW'((c - 1) % 3)) begin failures++; $display("FAIL rotate_waddr c=%0d got=%0d exp=%0d", c, rf_waddr, (c - 1) % 3); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rotate_ptr_back got=%b exp=001", req_ready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    q_valid[2] = 1'b1; q_addr[2] = 3'd1; q_data[2] = 16'h2222;
    @(negedge clk);
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL wrap_first got=%b exp=100", req_ready); end
    tick();
    q_valid[0] = 1'b1; q_addr[0] = 3'd6; q_data[0] = 16'h0000;
    q_data[2] = 16'h2223;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL wrap_second got=%b exp=001", req_ready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_valid = 1'b1; issue_addr = 3'd3;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_issue_ready got=%b exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    rd_en1 = 1'b1; rd_addr1 = 3'd3; rd_en2 = 1'b1; rd_addr2 = 3'd6;
    @(negedge clk);
    checks++; if (busy_mask !== 8'h08) begin failures++; $display("FAIL raw_busy got=%h exp=08", busy_mask); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall_wait c=%0d got=%b exp=1", c, stall); end
      tick();
    end
    q_valid[1] = 1'b1; q_addr[1] = 3'd3; q_data[1] = 16'h1234;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall_grant got=%b exp=1", stall); end
    tick();
    q_valid[1] = 1'b0;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL raw_we got=%b exp=1", rf_we); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall_we got=%b exp=1", stall); end
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_stall_clear got=%b exp=0", stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_waw();
    do_reset();
    issue_valid = 1'b1; issue_addr = 3'd4;
    tick();
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_blocked got=%b exp=0", issue_ready); end
    checks++; if (busy_mask !== 8'h10) begin failures++; $display("FAIL waw_busy got=%h exp=10", busy_mask); end
    q_valid[0] = 1'b1; q_addr[0] = 3'd4; q_data[0] = 16'h4444;
    tick();
    q_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_blocked_we got=%b exp=0", issue_ready); end
    tick();
    @(negedge clk);
    checks++; if (busy_mask !== 8'h00) begin failures++; $display("FAIL waw_cleared got=%h exp=00", busy_mask); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL waw_reissue got=%b exp=1", issue_ready); end
    tick();
    @(negedge clk);
    checks++; if (busy_mask !== 8'h10) begin failures++; $display("FAIL waw_reset_busy got=%h exp=10", busy_mask); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int a = 0; a < RN; a++) begin
      issue_valid = 1'b1; issue_addr = AW'(a);
      tick();
    end
    issue_valid = 1'b0;
    q_valid[1] = 1'b1; q_addr[1] = 3'd2; q_data[1] = 16'h5A5A;
    tick();
    for (int i = 0; i < NR; i++) q_valid[i] = 1'b1;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL mid_we_before got=%b exp=1", rf_we); end
    checks++; if (busy_mask !== 8'hFF) begin failures++; $display("FAIL mid_busy_before got=%h exp=ff", busy_mask); end
    tick();
    rst = 1'b1; issue_valid = 1'b1; issue_addr = 3'd0;
    @(negedge clk);
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL mid_req_ready got=%b exp=000", req_ready); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL mid_issue_ready got=%b exp=0", issue_ready); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_we_after got=%b exp=0", rf_we); end
    checks++; if (busy_mask !== 8'h00) begin failures++; $display("FAIL mid_busy_after got=%h exp=00", busy_mask); end
    tick();
  endtask

  task automatic test_random();
    logic pend [NR];
    int g;
    do_reset();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1; q_addr[i] = AW'($urandom); q_data[i] = RS'($urandom);
        end
        q_valid[i] = pend[i];
      end
      issue_valid = $urandom_range(0, 1) == 1; issue_addr = AW'($urandom);
      rd_en1 = $urandom_range(0, 1) == 1; rd_addr1 = AW'($urandom);
      rd_en2 = $urandom_range(0, 1) == 1; rd_addr2 = AW'($urandom);
      @(negedge clk);
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      checks++; if (issue_ready !== exp_issue_ready()) begin failures++; $display("FAIL rnd_issue c=%0d got=%b exp=%b", c, issue_ready, exp_issue_ready()); end
      checks++; if (stall !== exp_stall()) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_stall()); end
      checks++; if (rf_we !== m_we) begin failures++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, rf_we, m_we); end
      checks++; if (rf_waddr !== m_waddr) begin failures++; $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, rf_waddr, m_waddr); end
      checks++; if (rf_wdata !== m_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, rf_wdata, m_wdata); end
      checks++; if (busy_mask !== m_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy_mask, m_busy); end
      g = rst ? -1 : model_grant();
      if (g >= 0) pend[g] = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_rotation();
    test_wrap();
    test_raw_stall();
    test_waw();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
